// File: rtl/dm_ctrl.sv
// dm_ctrl: 32-bit data memory controller with byte/half/word access and post-reset clear.
// Optional alignment fault detection when DM_ALIGN_CHK_EN is defined.
module dm_ctrl #(
  parameter int ADDR_W = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        we,
  input  logic [1:0]  size,
  input  logic        sext,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [31:0] pc,
  output logic        ready,
  output logic        ack,
  output logic [31:0] rdata,
  output logic        exc,
  output logic        clearing
);
  localparam int DEPTH = 2**ADDR_W;
  typedef enum logic [1:0] {CLEAR, IDLE, ACCESS, RESP} state_t;
  state_t state_q, state_d;
  logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d;
  logic we_q, sext_q;
  logic [1:0] size_q;
  logic [31:0] addr_q, wdata_q, pc_q, rdata_q, rdata_d;
  logic [31:0] mem [DEPTH];
  logic fault, mem_we;
  logic [ADDR_W-1:0] mem_idx;
  logic [3:0] mem_be;
  logic [31:0] mem_wd, rword;
  logic [7:0] rbyte;
  logic [15:0] rhalf;
  logic unused;
`ifdef DM_ALIGN_CHK_EN
  assign fault = (size_q == 2'b01 && addr_q[0]) || (size_q == 2'b10 && addr_q[1:0] != 2'b00) || size_q == 2'b11;
`else
  assign fault = 1'b0;
`endif
  assign unused   = ^{pc_q, addr_q[31:ADDR_W+2]};
  assign ready    = state_q == IDLE;
  assign ack      = state_q == RESP;
  assign exc      = state_q == RESP && fault;
  assign clearing = state_q == CLEAR;
  assign rdata    = rdata_q;
  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    case (state_q)
      CLEAR: begin
        clr_cnt_d = clr_cnt_q + ADDR_W'(1);
        state_d   = &clr_cnt_q ? IDLE : CLEAR;
      end
      IDLE:    state_d = req ? ACCESS : IDLE;
      ACCESS:  state_d = RESP;
      default: state_d = IDLE;
    endcase
  end
  // One write port shared by the clear sweep and stores; lanes replicated so byte enables pick the target.
  always_comb begin
    mem_we  = state_q == CLEAR || (state_q == ACCESS && we_q && !fault);
    mem_idx = state_q == CLEAR ? clr_cnt_q : addr_q[ADDR_W+1:2];
    mem_be  = state_q == CLEAR ? 4'hf :
              size_q == 2'b00  ? 4'b0001 << addr_q[1:0] :
              size_q == 2'b01  ? (addr_q[1] ? 4'b1100 : 4'b0011) : 4'hf;
    mem_wd  = state_q == CLEAR ? 32'h0 :
              size_q == 2'b00  ? {4{wdata_q[7:0]}} :
              size_q == 2'b01  ? {2{wdata_q[15:0]}} : wdata_q;
    rword   = mem[addr_q[ADDR_W+1:2]];
    rbyte   = rword[{addr_q[1:0], 3'b000} +: 8];
    rhalf   = addr_q[1] ? rword[31:16] : rword[15:0];
    rdata_d = (state_q != ACCESS || we_q || fault) ? 32'h0 :
              size_q == 2'b00 ? {{24{sext_q & rbyte[7]}}, rbyte} :
              size_q == 2'b01 ? {{16{sext_q & rhalf[15]}}, rhalf} : rword;
  end
  always_ff @(posedge clk) begin
    for (int b = 0; b < 4; b++)
      if (mem_we && mem_be[b]) mem[mem_idx][8*b +: 8] <= mem_wd[8*b +: 8];
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= CLEAR;
      clr_cnt_q <= '0;
      rdata_q   <= '0;
      we_q      <= 1'b0;
      sext_q    <= 1'b0;
      size_q    <= 2'b00;
      addr_q    <= '0;
      wdata_q   <= '0;
      pc_q      <= '0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
      rdata_q   <= rdata_d;
      if (state_q == IDLE && req) begin
        we_q    <= we;
        sext_q  <= sext;
        size_q  <= size;
        addr_q  <= addr;
        wdata_q <= wdata;
        pc_q    <= pc;
      end
    end
  end
endmodule
